fmul_result_buffer: RTL and testbench

- Downstream consumer of the single-precision floating-point multiplier. Each cycle, it captures the multiplier's combinational product and its Exception/Overflow/Underflow flags whenever the upstream sequencer marks them valid.
- Buffers accepted results in a small FIFO and presents them to the writeback/bus side through a valid/ready handshake.
- Accumulates sticky status flags and a saturating count of flagged results for software status reads.

---
 rtl/fmul_result_buffer.sv | 116 +++++++++++
 tb/tb_fmul_result_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_result_buffer.sv
// fmul_result_buffer: captures floating-point multiplier results and flags,
// queues them in a small show-ahead FIFO, and keeps sticky status plus a
// saturating count of flagged results for software.
//
// Handshakes: a transfer on either side happens only in a cycle where the
// sender's valid and the receiver's ready are both high at the rising clock
// edge. in_ready depends only on rst and occupancy, never on out_ready.
// out_result/out_flags are valid whenever out_valid is high and read as 0
// otherwise.
module fmul_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16,
    parameter int NAN_ON_EXC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic                     in_exception,
    input  logic                     in_overflow,
    input  logic                     in_underflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic [2:0]               sticky_flags,
    output logic [CNT_W-1:0]         flag_count,
    input  logic                     sticky_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [31:0]      QNAN       = 32'h7FC0_0000;

    // Storage is deliberately left unreset; occupancy decides what is live.
    logic [31:0]      mem_result [DEPTH];
    logic [2:0]       mem_flags  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             wr_en;
    logic             rd_en;
    logic [2:0]       in_flags;
    logic [31:0]      wr_result;
    logic [2:0]       sticky_next;
    logic [CNT_W-1:0] count_base;
    logic [CNT_W-1:0] count_next;

    assign in_flags  = {in_exception, in_overflow, in_underflow};
    assign in_ready  = !rst && (level != FULL_LEVEL);
    assign out_valid = (level != '0);
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready && !rst;

    // Show-ahead head entry, masked to zero while empty.
    assign out_result = out_valid ? mem_result[rd_ptr] : 32'h0;
    assign out_flags  = out_valid ? mem_flags[rd_ptr]  : 3'b000;

    // Replace the product with a quiet NaN when the multiplier raised Exception.
    always_comb begin
        wr_result = in_result;
        if ((NAN_ON_EXC != 0) && in_exception) begin
            wr_result = QNAN;
        end
    end

    // Status update: clear is applied first, then the accepted write's flags.
    always_comb begin
        sticky_next = sticky_clr ? 3'b000 : sticky_flags;
        count_base  = sticky_clr ? '0 : flag_count;
        count_next  = count_base;
        if (wr_en) begin
            sticky_next = sticky_next | in_flags;
            if ((in_flags != 3'b000) && (count_base != CNT_MAX)) begin
                count_next = count_base + 1'b1;
            end
        end
    end

    // Store accepted entries at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_result[wr_ptr] <= wr_result;
            mem_flags[wr_ptr]  <= in_flags;
        end
    end

    // Pointers, occupancy and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            sticky_flags <= 3'b000;
            flag_count   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                level <= level + 1'b1;
            end else if (rd_en && !wr_en) begin
                level <= level - 1'b1;
            end
            sticky_flags <= sticky_next;
            flag_count   <= count_next;
        end
    end

endmodule

// File: tb/tb_fmul_result_buffer.sv
// Bench for fmul_result_buffer: directed scenarios plus random traffic,
// checked by a reference model with an expected-entry queue.
module tb_fmul_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_exception;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic [2:0]  level;
    logic [2:0]  sticky_flags;
    logic [1:0]  flag_count;
    logic        sticky_clr;

    fmul_result_buffer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W),
        .NAN_ON_EXC(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .in_exception(in_exception),
        .in_overflow(in_overflow),
        .in_underflow(in_underflow),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_flags(out_flags),
        .level(level),
        .sticky_flags(sticky_flags),
        .flag_count(flag_count),
        .sticky_clr(sticky_clr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [34:0] exp_q[$];
    logic [2:0]  m_sticky = 3'b000;
    logic [1:0]  m_count  = 2'd0;
    logic        mon_en   = 1'b0;
    logic        m_accept;
    logic        m_pop;
    logic [2:0]  m_flags;
    logic [31:0] m_result;
    logic [34:0] head;

    // Compare DUT state against the model mid-cycle, then advance the model
    // with the inputs that the next rising edge will see.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", in_ready, !rst && (exp_q.size() != DEPTH));
            check("level", level, exp_q.size());
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check("out_result", out_result, head[34:3]);
                check("out_flags", out_flags, head[2:0]);
            end else begin
                check("out_result_empty", out_result, 32'h0);
                check("out_flags_empty", out_flags, 3'b000);
            end
            check("sticky_flags", sticky_flags, m_sticky);
            check("flag_count", flag_count, m_count);

            m_flags  = {in_exception, in_overflow, in_underflow};
            m_result = in_exception ? 32'h7FC0_0000 : in_result;
            m_accept = in_valid && !rst && (exp_q.size() != DEPTH);
            m_pop    = out_ready && !rst && (exp_q.size() != 0);
            if (rst) begin
                exp_q.delete();
                m_sticky = 3'b000;
                m_count  = 2'd0;
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (sticky_clr) begin
                    m_sticky = 3'b000;
                    m_count  = 2'd0;
                end
                if (m_accept) begin
                    exp_q.push_back({m_result, m_flags});
                    m_sticky = m_sticky | m_flags;
                    if (m_flags != 3'b000 && m_count != 2'd3) m_count = m_count + 2'd1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic write(input logic [31:0] r, input logic [2:0] f);
        in_valid = 1'b1;
        in_result = r;
        {in_exception, in_overflow, in_underflow} = f;
        step();
        in_valid = 1'b0;
        in_result = 32'h0;
        {in_exception, in_overflow, in_underflow} = 3'b000;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 16 && level != 0; i++) step();
        out_ready = 1'b0;
        check("drain_empty", level, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_result = 32'h0;
        in_exception = 1'b0;
        in_overflow = 1'b0;
        in_underflow = 1'b0;
        out_ready = 1'b0;
        sticky_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_level", level, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", flag_count, 0);

        // Single product through an empty buffer.
        write(32'h40C0_0000, 3'b000);
        at_neg();
        check("t1_valid", out_valid, 1);
        check("t1_result", out_result, 32'h40C0_0000);
        check("t1_flags", out_flags, 3'b000);
        check("t1_level", level, 1);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t1_pop_level", level, 0);
        check("t1_pop_result", out_result, 32'h0);

        // Fill (wrapping the pointers), push against full, then drain in order.
        for (int i = 0; i < DEPTH; i++) write($urandom, 3'b000);
        check("t2_full_level", level, DEPTH);
        check("t2_full_ready", in_ready, 0);
        write(32'hDEAD_BEEF, 3'b000);
        check("t2_ignored_level", level, DEPTH);
        drain();
        check("t2_empty_valid", out_valid, 0);

        // Full with simultaneous push and pop: only the pop happens.
        for (int i = 0; i < DEPTH; i++) write($urandom, 3'b000);
        in_valid = 1'b1;
        in_result = 32'h1234_5678;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t3_level", level, 3);
        check("t3_ready", in_ready, 1);
        drain();

        // Exception result is replaced by quiet NaN.
        write(32'h0, 3'b100);
        at_neg();
        check("t4_result", out_result, 32'h7FC0_0000);
        check("t4_flags", out_flags, 3'b100);
        check("t4_sticky", sticky_flags, 3'b100);
        check("t4_count", flag_count, 1);
        step();
        drain();

        // Overflow, then clear coinciding with an underflow write.
        write(32'h7F80_0000, 3'b010);
        check("t5_sticky_pre", sticky_flags, 3'b110);
        sticky_clr = 1'b1;
        write(32'h0000_0001, 3'b001);
        sticky_clr = 1'b0;
        check("t5_sticky", sticky_flags, 3'b001);
        check("t5_count", flag_count, 1);
        drain();

        // Reset mid-stream discards held entries.
        for (int i = 0; i < 3; i++) write($urandom, 3'b010);
        check("t6_level_pre", level, 3);
        rst = 1'b1;
        at_neg();
        check("t6_ready_in_rst", in_ready, 0);
        step();
        rst = 1'b0;
        check("t6_level", level, 0);
        check("t6_valid", out_valid, 0);
        check("t6_sticky", sticky_flags, 3'b000);
        check("t6_count", flag_count, 0);
        write(32'h8000_0000, 3'b000);
        check("t6_first_out", out_result, 32'h8000_0000);
        drain();

        // Counter saturation.
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) write($urandom, (i % 2 == 0) ? 3'b010 : 3'b001);
        out_ready = 1'b0;
        check("t7_count_sat", flag_count, 3);
        check("t7_sticky", sticky_flags, 3'b011);
        drain();

        // Random traffic, including clears and -0.0 results.
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_result = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            in_exception = ($urandom_range(0, 5) == 0);
            in_overflow = ($urandom_range(0, 4) == 0);
            in_underflow = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sticky_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0;
        sticky_clr = 1'b0;
        in_exception = 1'b0;
        in_overflow = 1'b0;
        in_underflow = 1'b0;
        drain();
        step();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
